// File: rtl/y_sequence_monitor.sv
// Detects the decode word sequence A -> B -> C(Z=1), counts matches and
// queues a timestamp per match in a small FIFO drained over valid/ready.
module y_sequence_monitor #(
  parameter int CNT_W = 8,
  parameter int TS_W  = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [2:0]                 y_in,
  input  logic                       z_in,
  output logic                       match,
  output logic [CNT_W-1:0]           match_count,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TS_W-1:0]            out_ts,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [2:0] WORD_A = 3'b101;
  localparam logic [2:0] WORD_B = 3'b011;
  localparam logic [2:0] WORD_C = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    S1,
    S2
  } state_t;

  state_t             state_q, state_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [TS_W-1:0]    ts_q;
  logic [TS_W-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               overflow_q, overflow_d;
  logic               full, pop, push_ok;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    match_d = 1'b0;
    if (en) begin
      unique case (state_q)
        IDLE: state_d = (y_in == WORD_A) ? S1 : IDLE;
        S1: begin
          if (y_in == WORD_B)      state_d = S2;
          else if (y_in == WORD_A) state_d = S1;
          else                     state_d = IDLE;
        end
        S2: begin
          // A completed match returns to IDLE; only a fresh A restarts detection.
          if (y_in == WORD_C && z_in) begin
            state_d = IDLE;
            match_d = 1'b1;
          end else if (y_in == WORD_A) begin
            state_d = S1;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign full    = (level_q == LVL_W'(DEPTH));
  assign pop     = (level_q != '0) && out_ready;
  assign push_ok = match_d && (!full || pop);

  always_comb begin
    count_d = count_q;
    if (match_d && count_q != '1) count_d = count_q + CNT_W'(1);

    level_d = level_q;
    unique case ({push_ok, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    overflow_d = overflow_q | (match_d && full && !pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      match_q    <= 1'b0;
      count_q    <= '0;
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      match_q    <= match_d;
      count_q    <= count_d;
      ts_q       <= ts_q + TS_W'(1);
      level_q    <= level_d;
      overflow_q <= overflow_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // NOTE: storage is reset on purpose so out_ts reads 0 out of reset instead
  // of X; with DEPTH this small the reset flops are cheap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= ts_q;
    end
  end

  assign match       = match_q;
  assign match_count = count_q;
  assign out_valid   = (level_q != '0);
  assign out_ts      = mem_q[rd_ptr_q];
  assign level       = level_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_y_sequence_monitor.sv
// Directed bench for y_sequence_monitor: a queue of expected timestamps is
// filled when a matching word is driven and drained as the FIFO is popped.
module tb_y_sequence_monitor;

  localparam int DEPTH = 4;
  localparam logic [2:0] A = 3'b101;
  localparam logic [2:0] B = 3'b011;
  localparam logic [2:0] C = 3'b110;
  localparam logic [2:0] X = 3'b000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [2:0] y_in = 3'b000;
  logic       z_in = 1'b0;
  logic       out_ready = 1'b0;

  logic       match, out_valid, overflow;
  logic [7:0] match_count, out_ts;
  logic [2:0] level;

  logic       match2, out_valid2, overflow2;
  logic [1:0] match_count2;
  logic [7:0] out_ts2;
  logic [2:0] level2;

  int checks = 0;
  int errors = 0;

  logic [7:0] ts_m;
  logic [7:0] ts_q_m [$];
  logic [7:0] cnt_m;
  logic [1:0] cnt2_m;
  logic       ovf_m;

  y_sequence_monitor #(.CNT_W(8), .TS_W(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .en(en), .y_in(y_in), .z_in(z_in),
    .match(match), .match_count(match_count), .out_valid(out_valid),
    .out_ready(out_ready), .out_ts(out_ts), .level(level), .overflow(overflow)
  );

  y_sequence_monitor #(.CNT_W(2), .TS_W(8), .DEPTH(DEPTH)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .y_in(y_in), .z_in(z_in),
    .match(match2), .match_count(match_count2), .out_valid(out_valid2),
    .out_ready(out_ready), .out_ts(out_ts2), .level(level2), .overflow(overflow2)
  );

  always #5 clk = ~clk;

  // Reference free-running timestamp.
  always @(posedge clk or posedge reset) begin
    if (reset) ts_m <= 8'd0;
    else       ts_m <= ts_m + 8'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("match_count", 32'(match_count), 32'(cnt_m));
    check("match_count_sat", 32'(match_count2), 32'(cnt2_m));
    check("level", 32'(level), 32'(ts_q_m.size()));
    check("out_valid", 32'(out_valid), 32'(ts_q_m.size() != 0));
    check("overflow", 32'(overflow), 32'(ovf_m));
    if (ts_q_m.size() != 0) check("out_ts", 32'(out_ts), 32'(ts_q_m[0]));
  endtask

  // One clock edge with the given inputs; exp_m says whether this edge completes a match.
  task automatic step(input logic [2:0] y, input logic z, input logic e,
                      input logic rdy, input logic exp_m);
    logic pop_m;
    en = e; y_in = y; z_in = z; out_ready = rdy;
    pop_m = rdy && (ts_q_m.size() != 0);
    if (pop_m) void'(ts_q_m.pop_front());
    if (exp_m) begin
      if (cnt_m != 8'hff) cnt_m++;
      if (cnt2_m != 2'd3) cnt2_m++;
      if (ts_q_m.size() < DEPTH) ts_q_m.push_back(ts_m);
      else ovf_m = 1'b1;
    end
    @(posedge clk);
    #1;
    check("match", 32'(match), 32'(exp_m));
    check_outputs();
  endtask

  task automatic do_reset();
    en = 1'b0; y_in = X; z_in = 1'b0; out_ready = 1'b0;
    reset = 1'b1;
    #1;
    ts_q_m.delete();
    cnt_m = 8'd0; cnt2_m = 2'd0; ovf_m = 1'b0;
    check("rst_match", 32'(match), 32'd0);
    check("rst_out_ts", 32'(out_ts), 32'd0);
    check("rst_out_valid2", 32'(out_valid2), 32'd0);
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Idle, idle, A, B, C(z=1): a match every five edges.
  task automatic match5(input logic rdy_last);
    step(X, 1'b0, 1'b1, 1'b0, 1'b0);
    step(X, 1'b0, 1'b1, 1'b0, 1'b0);
    step(A, 1'b0, 1'b1, 1'b0, 1'b0);
    step(B, 1'b0, 1'b1, 1'b0, 1'b0);
    step(C, 1'b1, 1'b1, rdy_last, 1'b1);
  endtask

  initial begin
    cnt_m = 8'd0; cnt2_m = 2'd0; ovf_m = 1'b0;
    #3;
    do_reset();

    // Basic match with C sampled at ts 7.
    for (int i = 0; i < 5; i++) step(X, 1'b0, 1'b1, 1'b0, 1'b0);
    step(A, 1'b0, 1'b1, 1'b0, 1'b0);
    step(B, 1'b0, 1'b1, 1'b0, 1'b0);
    step(C, 1'b1, 1'b1, 1'b0, 1'b1);
    check("basic_ts", 32'(out_ts), 32'd7);
    check("basic_level", 32'(level), 32'd1);
    step(X, 1'b0, 1'b1, 1'b1, 1'b0);

    // Overlap and negatives, draining as we go.
    step(A, 1'b0, 1'b1, 1'b1, 1'b0);
    step(A, 1'b0, 1'b1, 1'b1, 1'b0);
    step(B, 1'b0, 1'b1, 1'b1, 1'b0);
    step(C, 1'b1, 1'b1, 1'b1, 1'b1);
    step(A, 1'b0, 1'b1, 1'b1, 1'b0);
    step(B, 1'b0, 1'b1, 1'b1, 1'b0);
    step(A, 1'b0, 1'b1, 1'b1, 1'b0);
    step(B, 1'b0, 1'b1, 1'b1, 1'b0);
    step(C, 1'b1, 1'b1, 1'b1, 1'b1);
    step(A, 1'b0, 1'b1, 1'b1, 1'b0);
    step(B, 1'b0, 1'b1, 1'b1, 1'b0);
    step(C, 1'b0, 1'b1, 1'b1, 1'b0);
    step(A, 1'b0, 1'b1, 1'b1, 1'b0);
    step(B, 1'b0, 1'b1, 1'b1, 1'b0);
    step(C, 1'b1, 1'b1, 1'b1, 1'b1);
    step(B, 1'b0, 1'b1, 1'b1, 1'b0);
    step(C, 1'b1, 1'b1, 1'b1, 1'b0);

    // Enable gap with garbage words.
    step(A, 1'b0, 1'b1, 1'b0, 1'b0);
    step(C, 1'b1, 1'b0, 1'b0, 1'b0);
    step(X, 1'b1, 1'b0, 1'b0, 1'b0);
    step(B, 1'b0, 1'b0, 1'b0, 1'b0);
    step(B, 1'b0, 1'b1, 1'b0, 1'b0);
    step(C, 1'b1, 1'b1, 1'b0, 1'b1);
    step(X, 1'b0, 1'b1, 1'b1, 1'b0);

    // FIFO full and overflow: matches at ts 3,8,13,18,23.
    do_reset();
    step(X, 1'b0, 1'b1, 1'b0, 1'b0);
    step(A, 1'b0, 1'b1, 1'b0, 1'b0);
    step(B, 1'b0, 1'b1, 1'b0, 1'b0);
    step(C, 1'b1, 1'b1, 1'b0, 1'b1);
    check("ovf_first_ts", 32'(out_ts), 32'd3);
    for (int i = 0; i < 4; i++) match5(1'b0);
    check("ovf_level", 32'(level), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("sat_count", 32'(match_count2), 32'd3);
    for (int i = 0; i < 5; i++) step(X, 1'b0, 1'b1, 1'b1, 1'b0);
    check("ovf_drained", 32'(out_valid), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Simultaneous push and pop while full.
    do_reset();
    for (int i = 0; i < 4; i++) match5(1'b0);
    match5(1'b1);
    check("full_pp_level", 32'(level), 32'd4);
    check("full_pp_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 5; i++) step(X, 1'b0, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of a sequence.
    step(A, 1'b0, 1'b1, 1'b0, 1'b0);
    step(B, 1'b0, 1'b1, 1'b0, 1'b0);
    do_reset();
    step(C, 1'b1, 1'b1, 1'b0, 1'b0);
    step(X, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
